// File: rtl/alu_mdu.sv
// alu_mdu: integer execute unit for the RV32/RV64 core.
// Decodes opcode/funct3/funct7, produces base ALU results in one cycle and
// runs M-extension multiply/divide iteratively (radix-2, XLEN iterations).
// The result lives in a single registered slot behind a valid/ready handshake.
// Optional feature macro: RV_M_EXT_EN (defined: MUL/DIV datapath present;
// undefined: funct7=0000001 R-type ops are flagged illegal).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: i_valid/o_ready; o_ready never depends on i_valid.
// Downstream: o_valid/i_ready; o_result/o_illegal hold while o_valid & !i_ready.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal,
    output logic [1:0]      dbg_state
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic            accept;
    logic [1:0]      state;
    logic [2:0]      alu_f3;
    logic            alu_sub;
    logic            alu_sra;
    logic            dec_illegal;
    logic            dec_mop;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] base_res;
    logic            m_done;
    logic [XLEN-1:0] m_result;

    assign o_ready   = (state == ST_IDLE) && (!o_valid || i_ready);
    assign accept    = i_valid && o_ready;
    assign dbg_state = state;
    assign shamt     = i_op_b[SHW-1:0];
    // Kept as its own assignment so the shift stays arithmetic.
    assign sra_res   = $signed(i_op_a) >>> shamt;

    // Instruction decode: pick the ALU function, SUB/SRA modifiers, M-op or illegal.
    always_comb begin
        alu_f3      = i_funct3;
        alu_sub     = 1'b0;
        alu_sra     = 1'b0;
        dec_illegal = 1'b0;
        dec_mop     = 1'b0;
        if (i_opcode == OPC_R) begin
            case (i_funct7)
                7'b0000000: ;
                7'b0100000: begin
                    if (i_funct3 == 3'b000)      alu_sub = 1'b1;
                    else if (i_funct3 == 3'b101) alu_sra = 1'b1;
                    else                         dec_illegal = 1'b1;
                end
                7'b0000001: begin
`ifdef RV_M_EXT_EN
                    dec_mop = 1'b1;
`else
                    dec_illegal = 1'b1;
`endif
                end
                default: dec_illegal = 1'b1;
            endcase
        end else if (i_opcode == OPC_I) begin
            alu_sra = (i_funct3 == 3'b101) && i_funct7[5];
        end else begin
            // Unrecognised opcodes fall through to a plain ADD.
            alu_f3 = 3'b000;
        end
    end

    // Base-ISA ALU, single cycle.
    always_comb begin
        alu_res = '0;
        case (alu_f3)
            3'b000: alu_res = alu_sub ? (i_op_a - i_op_b) : (i_op_a + i_op_b);
            3'b001: alu_res = i_op_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
            3'b100: alu_res = i_op_a ^ i_op_b;
            3'b101: alu_res = alu_sra ? sra_res : (i_op_a >> shamt);
            3'b110: alu_res = i_op_a | i_op_b;
            default: alu_res = i_op_a & i_op_b;
        endcase
    end

    assign base_res = dec_illegal ? '0 : alu_res;

`ifdef RV_M_EXT_EN
    logic [SHW-1:0]    cnt;
    logic [XLEN-1:0]   acc_hi;     // MUL: product high half; DIV: partial remainder
    logic [XLEN-1:0]   acc_lo;     // MUL: multiplier/product low; DIV: dividend/quotient
    logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [1:0]        m_f3;
    logic              neg_a;
    logic              neg_b;
    logic              b_zero;
    logic              a_signed;
    logic              b_signed;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also rs2.
    assign a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                      (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign mag_a    = (a_signed && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
    assign mag_b    = (b_signed && i_op_b[XLEN-1]) ? -i_op_b : i_op_b;

    // One shift-add or restoring-subtract step, chosen by the current state.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd};
        div_ge    = ~div_diff[XLEN];
        if (state == ST_MUL) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else begin
            hi_n = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
            lo_n = {acc_lo[XLEN-2:0], div_ge};
        end
    end

    // Sign correction and half/quotient/remainder selection on the final step.
    // A zero divisor yields an all-ones quotient regardless of rs1's sign.
    always_comb begin
        prod     = {hi_n, lo_n};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = b_zero ? '1 : ((neg_a ^ neg_b) ? -lo_n : lo_n);
        rem_fix  = neg_a ? -hi_n : hi_n;
        if (state == ST_MUL)
            m_result = (m_f3 == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            m_result = m_f3[1] ? rem_fix : quo_fix;
    end

    assign m_done = (state != ST_IDLE) && (cnt == SHW'(XLEN-1));

    // Iteration FSM: latch magnitudes on accept, then XLEN steps in MUL/DIV.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            m_f3   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && dec_mop) begin
                        state  <= i_funct3[2] ? ST_DIV : ST_MUL;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        opnd   <= mag_b;
                        m_f3   <= i_funct3[1:0];
                        neg_a  <= a_signed && i_op_a[XLEN-1];
                        neg_b  <= b_signed && i_op_b[XLEN-1];
                        b_zero <= (i_op_b == '0);
                    end
                end
                default: begin
                    acc_hi <= hi_n;
                    acc_lo <= lo_n;
                    cnt    <= cnt + 1'b1;
                    if (m_done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end
`else
    assign state    = ST_IDLE;
    assign m_done   = 1'b0;
    assign m_result = '0;
`endif

    // Result slot: load on base accept or M completion, clear when consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_illegal <= 1'b0;
        end else if (accept && !dec_mop) begin
            o_valid   <= 1'b1;
            o_result  <= base_res;
            o_illegal <= dec_illegal;
        end else if (m_done) begin
            o_valid   <= 1'b1;
            o_result  <= m_result;
            o_illegal <= 1'b0;
        end else if (i_ready) begin
            o_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed-vector bench for alu_mdu (XLEN=32) with an
// ISA-level reference model and a scoreboard of expected results and due cycles.
module tb_alu_mdu;

    localparam int XLEN = 32;
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_X = 7'b0000011;
    localparam logic [6:0] F7_0  = 7'b0000000;
    localparam logic [6:0] F7_A  = 7'b0100000;
    localparam logic [6:0] F7_M  = 7'b0000001;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [6:0]      i_opcode = '0;
    logic [2:0]      i_funct3 = '0;
    logic [6:0]      i_funct7 = '0;
    logic [XLEN-1:0] i_op_a = '0;
    logic [XLEN-1:0] i_op_b = '0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [XLEN-1:0] o_result;
    logic            o_illegal;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [XLEN:0] exp_q[$];   // {illegal, result}
    int            due_q[$];   // cycle at which the result must first appear

    alu_mdu #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_illegal(o_illegal), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial forever #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what the instruction must produce, from ISA arithmetic.
    function automatic logic [XLEN:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        int              sa;
        int              sb;
        longint          la;
        longint          lb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [4:0]      sh;
        logic            sub;
        logic            sra;
        logic [2:0]      op;
        logic [XLEN-1:0] r;
        sa = a;
        sb = b;
        la = longint'(sa);
        lb = longint'(sb);
        ua = 64'(a);
        ub = 64'(b);
        sh = b[4:0];
        sub = 1'b0;
        sra = 1'b0;
        op = f3;
        r = '0;
        p = '0;
        if (opc == OPC_R && f7 == F7_M) begin
`ifdef RV_M_EXT_EN
            case (f3)
                3'd0: begin p = ua * ub; r = p[31:0]; end
                3'd1: begin p = la * lb; r = p[63:32]; end
                3'd2: begin p = la * ub; r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                3'd4: begin
                    if (b == '0) r = '1;
                    else if (a == 32'h80000000 && b == '1) r = a;
                    else r = 32'(sa / sb);
                end
                3'd5: begin
                    if (b == '0) r = '1;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == '0) r = a;
                    else if (a == 32'h80000000 && b == '1) r = '0;
                    else r = 32'(sa % sb);
                end
                default: begin
                    if (b == '0) r = a;
                    else r = a % b;
                end
            endcase
            return {1'b0, r};
`else
            return {1'b1, {XLEN{1'b0}}};
`endif
        end
        if (opc == OPC_R) begin
            if (f7 == F7_A) begin
                if (f3 == 3'b000) sub = 1'b1;
                else if (f3 == 3'b101) sra = 1'b1;
                else return {1'b1, {XLEN{1'b0}}};
            end else if (f7 != F7_0) begin
                return {1'b1, {XLEN{1'b0}}};
            end
        end else if (opc == OPC_I) begin
            sra = (f3 == 3'b101) && f7[5];
        end else begin
            op = 3'b000;
        end
        case (op)
            3'd0: begin
                if (sub) r = a - b;
                else r = a + b;
            end
            3'd1: r = a << sh;
            3'd2: r = {31'b0, (sa < sb)};
            3'd3: r = {31'b0, (a < b)};
            3'd4: r = a ^ b;
            3'd5: begin
                if (sra) r = 32'(sa >>> sh);
                else r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {1'b0, r};
    endfunction

    function automatic int latency(input logic [6:0] opc, input logic [6:0] f7);
`ifdef RV_M_EXT_EN
        if (opc == OPC_R && f7 == F7_M) return XLEN + 1;
`else
        if (opc == OPC_R && f7 == F7_M) return 1;
`endif
        return 1;
    endfunction

    // Driver: called at a falling edge, returns at the falling edge after accept.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int guard;
        guard = 0;
        i_valid  = 1'b1;
        i_opcode = opc;
        i_funct3 = f3;
        i_funct7 = f7;
        i_op_a   = a;
        i_op_b   = b;
        while (!o_ready && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 64'(o_ready), 64'd1);
            i_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(opc, f3, f7, a, b));
        due_q.push_back(cyc + latency(opc, f7));
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Pins the model to a hand-computed value, then sends the op to the DUT.
    task automatic lit(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN:0] want);
        chk(name, 64'(model(opc, f3, f7, a, b)), 64'(want));
        issue(opc, f3, f7, a, b);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        @(negedge i_clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        due_q.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Scoreboard compare: each fresh result is popped and checked, held ones re-checked.
    initial begin : compare
        logic          prev_valid;
        logic          prev_cons;
        logic [XLEN:0] cur;
        int            due;
        prev_valid = 1'b0;
        prev_cons  = 1'b0;
        cur        = '0;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst) begin
                prev_valid = 1'b0;
                prev_cons  = 1'b0;
            end else begin
                if (o_valid) begin
                    if (!prev_valid || prev_cons) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 64'(o_valid), 64'd0);
                        end else begin
                            cur = exp_q.pop_front();
                            due = due_q.pop_front();
                            chk("result", 64'({o_illegal, o_result}), 64'(cur));
                            chk("latency_cycle", 64'(cyc), 64'(due));
                        end
                    end else begin
                        chk("held_result", 64'({o_illegal, o_result}), 64'(cur));
                    end
                end
                prev_valid = o_valid;
                prev_cons  = o_valid && i_ready;
            end
            cyc++;
        end
    end

    // Directed stimulus
    initial begin : stim
        logic seen;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_ready", 64'(o_ready), 64'd1);
        chk("reset_result", 64'(o_result), 64'd0);
        chk("reset_illegal", 64'(o_illegal), 64'd0);

        // Base ops, back to back with i_ready high
        lit("add_r", OPC_R, 3'd0, F7_0, 32'd7, -32'sd3, {1'b0, 32'd4});
        lit("srai", OPC_I, 3'd5, F7_A, 32'h80000000, 32'd4, {1'b0, 32'hF8000000});
        lit("sub", OPC_R, 3'd0, F7_A, 32'd10, 32'd15, {1'b0, 32'hFFFFFFFB});
        lit("sltu", OPC_R, 3'd3, F7_0, 32'd1, 32'hFFFFFFFF, {1'b0, 32'd1});
        lit("and", OPC_R, 3'd7, F7_0, 32'h0000F0F0, 32'h00000FF0, {1'b0, 32'h000000F0});
        lit("slt", OPC_R, 3'd2, F7_0, 32'hFFFFFFFF, 32'd1, {1'b0, 32'd1});
        lit("srl", OPC_R, 3'd5, F7_0, 32'h80000000, 32'd31, {1'b0, 32'd1});
        lit("sll_mask", OPC_R, 3'd1, F7_0, 32'd1, 32'd33, {1'b0, 32'd2});
        lit("other_opc_add", OPC_X, 3'd6, 7'h7F, 32'd100, 32'd23, {1'b0, 32'd123});
        issue(OPC_R, 3'd4, F7_0, 32'hA5A5A5A5, 32'h0F0F0F0F);
        issue(OPC_R, 3'd6, F7_0, 32'h12340000, 32'h00005678);
        issue(OPC_I, 3'd0, 7'h7F, 32'd5, 32'hFFFFFFFE);
        issue(OPC_I, 3'd1, 7'h20, 32'h00000003, 32'd4);
        issue(OPC_I, 3'd5, F7_0, 32'h80000000, 32'd4);
        issue(OPC_I, 3'd2, F7_0, 32'd3, 32'hFFFFFFFF);
        drain();

        // Downstream stall: result held, o_ready low
        i_ready = 1'b0;
        issue(OPC_R, 3'd4, F7_0, 32'h00001234, 32'h000000FF);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 64'(o_ready), 64'd0);
            chk("stall_hold", 64'(o_result), 64'h000012CB);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        drain();

        // Undecodable R-type
        lit("illegal_f7a_sll", OPC_R, 3'd1, F7_A, 32'd1, 32'd1, {1'b1, 32'd0});
        lit("illegal_f7_02", OPC_R, 3'd0, 7'b0000010, 32'd1, 32'd1, {1'b1, 32'd0});
        drain();

`ifdef RV_M_EXT_EN
        lit("mulh_min", OPC_R, 3'd1, F7_M, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000});
        chk("mul_busy_ready", 64'(o_ready), 64'd0);
        lit("mulhsu", OPC_R, 3'd2, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFF});
        lit("mul_lo", OPC_R, 3'd0, F7_M, 32'hFFFFFFFF, 32'd3, {1'b0, 32'hFFFFFFFD});
        lit("mulhu", OPC_R, 3'd3, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE});
        lit("div_neg", OPC_R, 3'd4, F7_M, -32'sd7, 32'd2, {1'b0, 32'hFFFFFFFD});
        chk("div_busy_ready", 64'(o_ready), 64'd0);
        lit("rem_neg", OPC_R, 3'd6, F7_M, -32'sd7, 32'd2, {1'b0, 32'hFFFFFFFF});
        lit("divu_zero", OPC_R, 3'd5, F7_M, 32'd5, 32'd0, {1'b0, 32'hFFFFFFFF});
        lit("rem_zero", OPC_R, 3'd6, F7_M, 32'd5, 32'd0, {1'b0, 32'd5});
        lit("div_ovf", OPC_R, 3'd4, F7_M, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h80000000});
        lit("rem_ovf", OPC_R, 3'd6, F7_M, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'd0});
        lit("div_neg_zero", OPC_R, 3'd4, F7_M, -32'sd5, 32'd0, {1'b0, 32'hFFFFFFFF});
        lit("rem_neg_zero", OPC_R, 3'd6, F7_M, -32'sd5, 32'd0, {1'b0, 32'hFFFFFFFB});
        lit("divu_big", OPC_R, 3'd5, F7_M, 32'hFFFFFFFF, 32'd3, {1'b0, 32'h55555555});
        lit("remu", OPC_R, 3'd7, F7_M, 32'd100, 32'd7, {1'b0, 32'd2});
        issue(OPC_R, 3'd0, F7_0, 32'd1, 32'd1);
        drain();

        // Reset during a divide: no result may appear
        issue(OPC_R, 3'd4, F7_M, -32'sd100, 32'd7);
        repeat (9) @(negedge i_clk);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | o_valid;
            @(negedge i_clk);
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        lit("add_after_abort", OPC_R, 3'd0, F7_0, 32'd2, 32'd2, {1'b0, 32'd4});
        drain();
`else
        lit("mul_illegal", OPC_R, 3'd0, F7_M, 32'd3, 32'd4, {1'b1, 32'd0});
        lit("div_illegal", OPC_R, 3'd4, F7_M, 32'd8, 32'd2, {1'b1, 32'd0});
        drain();
`endif

        // Reset while a result is stalled in the slot
        i_ready = 1'b0;
        issue(OPC_R, 3'd0, F7_0, 32'd9, 32'd9);
        do_reset();
        chk("rst_slot_valid", 64'(o_valid), 64'd0);
        chk("rst_slot_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        lit("add_after_reset", OPC_R, 3'd0, F7_0, 32'hFFFFFFFF, 32'd1, {1'b0, 32'd0});
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute unit for the RV32/RV64 integer core, succeeding the combinational ALU-op decoder. It decodes opcode/funct3/funct7, computes base-ISA ALU results in one cycle, and runs M-extension multiply/divide iteratively. It sits between the register-read and writeback stages behind a valid/ready handshake on both sides, with a registered result slot.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  unit can accept an operation this cycle.
- i_opcode  in  7  0110011 (R-type) or 0010011 (I-type ALU); any other opcode executes ADD.
- i_funct3  in  3  instruction funct3.
- i_funct7  in  7  instruction funct7; for I-type, only bit 5 is used, and only when funct3=101.
- i_op_a  in  XLEN  rs1 value.
- i_op_b  in  XLEN  rs2 value or sign-extended immediate.
- o_valid  out  1  result slot holds a result.
- i_ready  in  1  downstream consumes the result.
- o_result  out  XLEN  result.
- o_illegal  out  1  result flagged as undecodable; o_result=0.

## Operation
- States: IDLE, MUL, DIV.
- An operation is accepted when i_valid & o_ready. o_ready = (state==IDLE) & (!o_valid | i_ready).
- Base ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND):
  - Decoded exactly as RV32I.
  - SUB only for R-type with funct7=0100000. SRA for funct3=101 with funct7[5]=1.
  - Shifts use i_op_b[SHW-1:0].
  - The result is written to the slot on the accept edge. State stays IDLE.
- R-type with funct7=0000001 (M ops):
  - funct3 0-3 (MUL, MULH, MULHSU, MULHU): IDLE→MUL.
  - funct3 4-7 (DIV, DIVU, REM, REMU): IDLE→DIV.
- R-type with any other funct7/funct3 combination: the slot is loaded with o_illegal=1 and o_result=0.
- MUL:
  - Operand magnitudes are latched at accept (signedness per funct3).
  - Radix-2 shift-add into a 2·XLEN accumulator for XLEN cycles.
  - On the final iteration: apply the sign correction, select the low half (MUL) or high half (others), write the slot, return to IDLE.
- DIV:
  - Restoring division on magnitudes for XLEN cycles.
  - On the final iteration: sign-correct (quotient sign = sa^sb; remainder sign = sa), select quotient or remainder, write the slot, return to IDLE.
- Divisor 0:
  - Quotient = all ones; remainder = i_op_a.
  - Takes the full XLEN cycles with no early-out.
- Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a, remainder = 0.
- Result slot:
  - Holds its value while o_valid & !i_ready.
  - Cleared (o_valid=0) on i_ready when not reloaded in the same cycle.
  - A same-cycle consume and new accept reloads the slot: back-to-back base ops give one result per cycle.
- Asserting reset mid-iteration aborts the operation; no result is produced.

## Timing
- Reset values: state=IDLE, o_valid=0, o_result=0, o_illegal=0, o_ready=1 after reset deasserts. Iteration counters and accumulators are cleared.
- Base op: o_valid on the cycle after accept (latency 1).
- M op: o_valid rises XLEN+1 cycles after the accept edge (33 for XLEN=32). o_ready is low throughout.
- o_ready is combinational from state, o_valid and i_ready. There is no path from i_valid to o_ready.
- Upstream must hold inputs stable only for the accept cycle. Operands are latched internally.

## Configuration
- RV_M_EXT_EN defined:
  - MUL/DIV datapath and MUL/DIV states are present, as described above.
- RV_M_EXT_EN undefined:
  - The datapath and states are removed.
  - funct7=0000001 R-type ops are treated as illegal (o_illegal=1, o_result=0, latency 1).
  - o_ready = !o_valid | i_ready.

## Test plan
- After reset: o_valid=0, o_ready=1. R-type ADD 7+(-3) → o_result=4 one cycle later. I-type funct3=101, funct7[5]=1, a=0x80000000, b=4 → 0xF8000000.
- Back-to-back SUB, SLTU, AND with i_ready held at 1 → one result per cycle in order. Then drop i_ready for 3 cycles → o_result held, o_ready=0.
- MULH a=0x80000000, b=0x80000000 (XLEN=32) → 0x40000000 after 33 cycles. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7, b=2 → -3. REM a=-7, b=2 → -1. DIVU a=5, b=0 → 0xFFFFFFFF. REM a=5, b=0 → 5. DIV 0x80000000/-1 → 0x80000000.
- Reset pulse at cycle 10 of a DIV → no o_valid. The next ADD completes normally with latency 1.
- Build without RV_M_EXT_EN, issue MUL → o_illegal=1, o_result=0 after 1 cycle. R-type funct7=0100000, funct3=001 → o_illegal=1.
